// File: rtl/mxv_relu_seq_ctrl.sv
// mxv_relu_seq_ctrl: sequential y = relu(W*x) for one fully-connected layer.
// One shared multiply-accumulate consumes weights streamed from an external
// memory (one entry per granted read, data one cycle later). x is latched at
// start. Each row's ReLU result is emitted as a one-cycle y_valid pulse and
// written into the persistent result vector o.
//
// Handshake: a read transfers on a cycle where w_rd_en && w_gnt are both high.
// While w_rd_en is high and w_gnt is low, w_rd_en and w_addr hold steady.
// w_data is consumed exactly one cycle after each transfer.
module mxv_relu_seq_ctrl #(
  parameter int N  = 8,
  parameter int J  = 3,
  parameter int K  = 3,
  parameter int L  = 2*N+K-1,
  parameter int AW = $clog2(J*K),
  parameter int JW = (J > 1) ? $clog2(J) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [K*N-1:0]    e_input,
  output logic              busy,
  output logic              done,
  output logic              w_rd_en,
  output logic [AW-1:0]     w_addr,
  input  logic              w_gnt,
  input  logic [N-1:0]      w_data,
  output logic              y_valid,
  output logic [JW-1:0]     y_idx,
  output logic [L-2:0]      y_data,
  output logic [J*(L-1)-1:0] o
);

  localparam int OW = L - 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int CW = $clog2(J*K+1);
  localparam logic [CW-1:0] TOTAL = CW'(J*K);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  w_rd_en_q, w_rd_en_d;
  logic [AW-1:0]         w_addr_q, w_addr_d;
  logic [CW-1:0]         issue_q, issue_d;
  logic                  data_exp_q, data_exp_d;
  logic [KW-1:0]         k_q, k_d;
  logic [JW-1:0]         row_q, row_d;
  logic signed [L-1:0]   acc_q, acc_d;
  logic signed [N-1:0]   x_q [K];
  logic signed [N-1:0]   x_d [K];
  logic                  y_valid_q, y_valid_d;
  logic [JW-1:0]         y_idx_q, y_idx_d;
  logic [OW-1:0]         y_data_q, y_data_d;
  logic [J*OW-1:0]       o_q, o_d;

  logic signed [2*N-1:0] prod;
  logic signed [L-1:0]   prod_ext;
  logic signed [L-1:0]   sum;
  logic [OW-1:0]         relu;
  logic [CW-1:0]         issue_nx;

  // Next-state, counters, MAC datapath and registered output values
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    w_rd_en_d  = w_rd_en_q;
    w_addr_d   = w_addr_q;
    issue_d    = issue_q;
    data_exp_d = data_exp_q;
    k_d        = k_q;
    row_d      = row_q;
    acc_d      = acc_q;
    x_d        = x_q;
    y_valid_d  = 1'b0;
    y_idx_d    = y_idx_q;
    y_data_d   = y_data_q;
    o_d        = o_q;

    prod     = x_q[k_q] * $signed(w_data);
    prod_ext = L'(prod);
    sum      = acc_q + prod_ext;
    relu     = sum[L-1] ? '0 : sum[OW-1:0];
    issue_nx = issue_q + CW'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int k = 0; k < K; k++) begin
            x_d[k] = $signed(e_input[k*N +: N]);
          end
          issue_d    = '0;
          data_exp_d = 1'b0;
          k_d        = '0;
          row_d      = '0;
          acc_d      = '0;
          busy_d     = 1'b1;
          w_rd_en_d  = 1'b1;
          w_addr_d   = '0;
          state_d    = S_RUN;
        end
      end

      S_RUN: begin
        // Read issue side: advance only on a transferred request
        if (w_rd_en_q && w_gnt) begin
          issue_d    = issue_nx;
          data_exp_d = 1'b1;
          if (issue_nx < TOTAL) begin
            w_addr_d = AW'(issue_nx);
          end else begin
            w_rd_en_d = 1'b0;
          end
        end else begin
          data_exp_d = 1'b0;
        end

        // Data side: one MAC per returned beat, row closes on the last column
        if (data_exp_q) begin
          if (k_q == KW'(K-1)) begin
            y_valid_d = 1'b1;
            y_idx_d   = row_q;
            y_data_d  = relu;
            o_d[int'(row_q)*OW +: OW] = relu;
            acc_d     = '0;
            k_d       = '0;
            row_d     = row_q + JW'(1);
            if (row_q == JW'(J-1)) begin
              done_d  = 1'b1;
              state_d = S_FIN;
            end
          end else begin
            acc_d = sum;
            k_d   = k_q + KW'(1);
          end
        end
      end

      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        w_rd_en_d = 1'b0;
      end
    endcase
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      w_rd_en_q  <= 1'b0;
      w_addr_q   <= '0;
      issue_q    <= '0;
      data_exp_q <= 1'b0;
      k_q        <= '0;
      row_q      <= '0;
      acc_q      <= '0;
      x_q        <= '{default: '0};
      y_valid_q  <= 1'b0;
      y_idx_q    <= '0;
      y_data_q   <= '0;
      o_q        <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      w_rd_en_q  <= w_rd_en_d;
      w_addr_q   <= w_addr_d;
      issue_q    <= issue_d;
      data_exp_q <= data_exp_d;
      k_q        <= k_d;
      row_q      <= row_d;
      acc_q      <= acc_d;
      x_q        <= x_d;
      y_valid_q  <= y_valid_d;
      y_idx_q    <= y_idx_d;
      y_data_q   <= y_data_d;
      o_q        <= o_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign w_rd_en = w_rd_en_q;
  assign w_addr  = w_addr_q;
  assign y_valid = y_valid_q;
  assign y_idx   = y_idx_q;
  assign y_data  = y_data_q;
  assign o       = o_q;

endmodule

// File: tb/tb_mxv_relu_seq_ctrl.sv
// Bench for mxv_relu_seq_ctrl: weight memory model, per-scenario tasks and
// an arithmetic reference model of y = relu(W*x).
module tb_mxv_relu_seq_ctrl;
  localparam int N  = 8;
  localparam int J  = 3;
  localparam int K  = 3;
  localparam int L  = 2*N+K-1;
  localparam int OW = L-1;
  localparam int AW = $clog2(J*K);
  localparam int JW = 2;

  logic              clk, rst_n, start, busy, done, w_rd_en, w_gnt, y_valid;
  logic [K*N-1:0]    e_input;
  logic [AW-1:0]     w_addr;
  logic [N-1:0]      w_data;
  logic [JW-1:0]     y_idx;
  logic [OW-1:0]     y_data;
  logic [J*OW-1:0]   o;

  mxv_relu_seq_ctrl #(.N(N), .J(J), .K(K)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .e_input(e_input), .busy(busy),
    .done(done), .w_rd_en(w_rd_en), .w_addr(w_addr), .w_gnt(w_gnt),
    .w_data(w_data), .y_valid(y_valid), .y_idx(y_idx), .y_data(y_data), .o(o)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // weight memory: data one cycle after a granted read, junk otherwise
  logic signed [N-1:0] w_mem [J*K];
  int grant_total [J*K];
  always @(posedge clk) begin
    if (w_rd_en && w_gnt) begin
      w_data <= w_mem[w_addr];
      grant_total[w_addr] <= grant_total[w_addr] + 1;
    end else begin
      w_data <= N'($urandom);
    end
  end

  int checks = 0;
  int errors = 0;

  int got_y [J];
  int got_cyc [J];
  int got_vcount, done_cyc, stall_err, timed_out, busy_c1;
  logic busy_after;
  int gcount [J*K];
  int basic_w [J*K] = '{-1, 2, -3, 2, 3, -4, -4, 5, 7};

  // reference model
  function automatic int model_row(input int j, input logic [K*N-1:0] xv);
    int s = 0;
    for (int k = 0; k < K; k++)
      s += int'(w_mem[j*K+k]) * int'($signed(xv[k*N +: N]));
    return (s < 0) ? 0 : s;
  endfunction

  function automatic logic [J*OW-1:0] model_o(input logic [K*N-1:0] xv);
    logic [J*OW-1:0] r = '0;
    for (int j = 0; j < J; j++) r[j*OW +: OW] = OW'(model_row(j, xv));
    return r;
  endfunction

  function automatic logic [K*N-1:0] mk_x(input int a, input int b, input int c);
    return {N'(c), N'(b), N'(a)};
  endfunction

  function automatic logic gnt_for(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c >= 8 && c <= 12) ? 1'b0 : (c % 2 == 1);
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic load_basic_w();
    for (int i = 0; i < J*K; i++) w_mem[i] = N'(basic_w[i]);
  endtask

  // driver: runs one layer from a negedge; returns at the negedge after done
  task automatic run_layer(input logic [K*N-1:0] xv, input int mode, input bit extra);
    int base [J*K];
    int c = 0;
    bit fin = 0;
    logic prev_rd, prev_gnt;
    logic [AW-1:0] prev_addr;
    for (int i = 0; i < J*K; i++) base[i] = grant_total[i];
    for (int j = 0; j < J; j++) begin got_y[j] = -1; got_cyc[j] = -1; end
    got_vcount = 0; done_cyc = -1; stall_err = 0; timed_out = 0; busy_c1 = -1;
    busy_after = 1'bx;
    start = 1'b1; e_input = xv; w_gnt = gnt_for(mode, 0);
    prev_rd = 1'b0; prev_gnt = 1'b1; prev_addr = '0;
    while (!fin) begin
      @(negedge clk); c++;
      if (c == 1) busy_c1 = int'(busy);
      if (prev_rd && !prev_gnt && (w_rd_en !== 1'b1 || w_addr !== prev_addr)) stall_err++;
      if (y_valid === 1'b1) begin
        got_vcount++;
        if (y_idx < J) begin got_y[y_idx] = int'(y_data); got_cyc[y_idx] = c; end
      end
      start = extra && (c == 3 || c == 7);
      if (extra) e_input = K*N'($urandom);
      w_gnt = gnt_for(mode, c);
      prev_rd = w_rd_en; prev_gnt = w_gnt; prev_addr = w_addr;
      if (done === 1'b1) begin
        done_cyc = c;
        start = 1'b0;
        @(negedge clk);
        busy_after = busy;
        fin = 1;
      end else if (c > 400) begin
        timed_out = 1;
        start = 1'b0;
        fin = 1;
      end
    end
    for (int i = 0; i < J*K; i++) gcount[i] = grant_total[i] - base[i];
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, w_rd_en, y_valid, w_addr, y_idx, y_data, o} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0",
                         {busy, done, w_rd_en, y_valid, w_addr, y_idx, y_data, o});
    end
  endtask

  task automatic test_basic();
    int exp_y [J] = '{16, 29, 0};
    logic [J*OW-1:0] exp_o = {17'd0, 17'd29, 17'd16};
    load_basic_w();
    run_layer(mk_x(2, 3, -4), 0, 0);
    checks++; if (timed_out !== 0) begin errors++; $display("FAIL basic_timeout: got %0d expected 0", timed_out); end
    checks++; if (busy_c1 !== 1) begin errors++; $display("FAIL basic_busy_c1: got %0d expected 1", busy_c1); end
    for (int j = 0; j < J; j++) begin
      checks++; if (got_y[j] !== exp_y[j]) begin errors++; $display("FAIL basic_y%0d: got %0d expected %0d", j, got_y[j], exp_y[j]); end
      checks++; if (got_cyc[j] !== (j+1)*K+2) begin errors++; $display("FAIL basic_cyc%0d: got %0d expected %0d", j, got_cyc[j], (j+1)*K+2); end
    end
    checks++; if (done_cyc !== J*K+2) begin errors++; $display("FAIL basic_done_cyc: got %0d expected %0d", done_cyc, J*K+2); end
    checks++; if (got_vcount !== J) begin errors++; $display("FAIL basic_vcount: got %0d expected %0d", got_vcount, J); end
    checks++; if (o !== exp_o) begin errors++; $display("FAIL basic_o: got %h expected %h", o, exp_o); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", busy_after); end
  endtask

  task automatic test_extremes();
    int exp_v [2] = '{49152, 0};
    logic [K*N-1:0] xs [2];
    xs[0] = mk_x(-128, -128, -128);
    xs[1] = mk_x(127, 127, 127);
    for (int i = 0; i < J*K; i++) w_mem[i] = -8'sd128;
    for (int t = 0; t < 2; t++) begin
      run_layer(xs[t], 0, 0);
      checks++; if (timed_out !== 0) begin errors++; $display("FAIL ext_timeout: got %0d expected 0", timed_out); end
      for (int j = 0; j < J; j++) begin
        checks++; if (got_y[j] !== exp_v[t]) begin errors++; $display("FAIL ext%0d_y%0d: got %0d expected %0d", t, j, got_y[j], exp_v[t]); end
      end
      checks++; if (o !== {J{OW'(exp_v[t])}}) begin errors++; $display("FAIL ext%0d_o: got %h expected %h", t, o, {J{OW'(exp_v[t])}}); end
    end
  endtask

  task automatic test_stall();
    int exp_y [J] = '{16, 29, 0};
    load_basic_w();
    run_layer(mk_x(2, 3, -4), 1, 0);
    checks++; if (timed_out !== 0) begin errors++; $display("FAIL stall_timeout: got %0d expected 0", timed_out); end
    for (int j = 0; j < J; j++) begin
      checks++; if (got_y[j] !== exp_y[j]) begin errors++; $display("FAIL stall_y%0d: got %0d expected %0d", j, got_y[j], exp_y[j]); end
    end
    checks++; if (o !== {17'd0, 17'd29, 17'd16}) begin errors++; $display("FAIL stall_o: got %h expected %h", o, {17'd0, 17'd29, 17'd16}); end
    checks++; if (stall_err !== 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", stall_err); end
    for (int i = 0; i < J*K; i++) begin
      checks++; if (gcount[i] !== 1) begin errors++; $display("FAIL stall_grant%0d: got %0d expected 1", i, gcount[i]); end
    end
    checks++; if (done_cyc !== got_cyc[J-1]) begin errors++; $display("FAIL stall_done_cyc: got %0d expected %0d", done_cyc, got_cyc[J-1]); end
  endtask

  task automatic test_start_ignored();
    logic [K*N-1:0] xv = mk_x(2, 3, -4);
    load_basic_w();
    run_layer(xv, 0, 1);
    checks++; if (timed_out !== 0) begin errors++; $display("FAIL ign_timeout: got %0d expected 0", timed_out); end
    for (int j = 0; j < J; j++) begin
      checks++; if (got_y[j] !== model_row(j, xv)) begin errors++; $display("FAIL ign_y%0d: got %0d expected %0d", j, got_y[j], model_row(j, xv)); end
      checks++; if (got_cyc[j] !== (j+1)*K+2) begin errors++; $display("FAIL ign_cyc%0d: got %0d expected %0d", j, got_cyc[j], (j+1)*K+2); end
    end
    checks++; if (got_vcount !== J) begin errors++; $display("FAIL ign_vcount: got %0d expected %0d", got_vcount, J); end
  endtask

  task automatic test_async_reset();
    logic [K*N-1:0] xv = mk_x(4, 4, 1);
    load_basic_w();
    start = 1'b1; e_input = mk_x(2, 3, -4); w_gnt = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, w_rd_en, y_valid, w_addr, y_idx, y_data} !== '0) begin
      errors++; $display("FAIL areset_ctrl: got %h expected 0", {busy, done, w_rd_en, y_valid, w_addr, y_idx, y_data});
    end
    checks++; if (o !== '0) begin errors++; $display("FAIL areset_o: got %h expected 0", o); end
    @(negedge clk); rst_n = 1'b1;
    run_layer(xv, 0, 0);
    checks++; if (timed_out !== 0) begin errors++; $display("FAIL areset_timeout: got %0d expected 0", timed_out); end
    for (int j = 0; j < J; j++) begin
      checks++; if (got_y[j] !== model_row(j, xv)) begin errors++; $display("FAIL areset_y%0d: got %0d expected %0d", j, got_y[j], model_row(j, xv)); end
    end
    checks++; if (o !== model_o(xv)) begin errors++; $display("FAIL areset_o2: got %h expected %h", o, model_o(xv)); end
  endtask

  task automatic test_back_to_back();
    int exp_y [J] = '{0, 1, 8};
    load_basic_w();
    run_layer(mk_x(2, 3, -4), 0, 0);
    run_layer(mk_x(1, 1, 1), 0, 0);
    checks++; if (timed_out !== 0) begin errors++; $display("FAIL b2b_timeout: got %0d expected 0", timed_out); end
    for (int j = 0; j < J; j++) begin
      checks++; if (got_y[j] !== exp_y[j]) begin errors++; $display("FAIL b2b_y%0d: got %0d expected %0d", j, got_y[j], exp_y[j]); end
      checks++; if (got_cyc[j] !== (j+1)*K+2) begin errors++; $display("FAIL b2b_cyc%0d: got %0d expected %0d", j, got_cyc[j], (j+1)*K+2); end
    end
    checks++; if (o !== {17'd8, 17'd1, 17'd0}) begin errors++; $display("FAIL b2b_o: got %h expected %h", o, {17'd8, 17'd1, 17'd0}); end
  endtask

  task automatic test_random();
    logic [K*N-1:0] xv;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < J*K; i++) w_mem[i] = N'($urandom);
      xv = K*N'($urandom);
      run_layer(xv, 2, 0);
      checks++; if (timed_out !== 0) begin errors++; $display("FAIL rnd%0d_timeout: got %0d expected 0", it, timed_out); end
      for (int j = 0; j < J; j++) begin
        checks++; if (got_y[j] !== model_row(j, xv)) begin errors++; $display("FAIL rnd%0d_y%0d: got %0d expected %0d", it, j, got_y[j], model_row(j, xv)); end
      end
      checks++; if (o !== model_o(xv)) begin errors++; $display("FAIL rnd%0d_o: got %h expected %h", it, o, model_o(xv)); end
      checks++; if (stall_err !== 0) begin errors++; $display("FAIL rnd%0d_hold: got %0d expected 0", it, stall_err); end
      for (int i = 0; i < J*K; i++) begin
        checks++; if (gcount[i] !== 1) begin errors++; $display("FAIL rnd%0d_grant%0d: got %0d expected 1", it, i, gcount[i]); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; e_input = '0; w_gnt = 1'b0;
    for (int i = 0; i < J*K; i++) w_mem[i] = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_extremes();
    test_stall();
    test_start_ignored();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
